// File: rtl/shift_arithmetic_left_seq_if.sv
// Operand/result handshake bundle for the sequential arithmetic-left shifter.
// master = producer/consumer side, slave = shifter side.
interface shift_arithmetic_left_seq_if #(
   parameter int Nbits   = 32,
   parameter int ShWidth = $clog2(Nbits)
);
   logic               in_valid;
   logic               in_ready;
   logic [Nbits-1:0]   In;
   logic [ShWidth-1:0] ShAmt;
   logic               out_valid;
   logic               out_ready;
   logic [Nbits-1:0]   Out;
   logic               Overflow;

   modport master (
      output in_valid, In, ShAmt, out_ready,
      input  in_ready, out_valid, Out, Overflow
   );

   modport slave (
      input  in_valid, In, ShAmt, out_ready,
      output in_ready, out_valid, Out, Overflow
   );
endinterface

// File: rtl/shift_arithmetic_left_seq.sv
// Multi-cycle arithmetic left shifter: one bit per clock, zero fill, signed overflow flag.
// Optional macro SAL_SATURATE_EN clamps an overflowed result to the signed extreme.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand
// SHIFT | shifting acc left one bit per cycle, cnt counts down to 1
// DONE  | out_valid=1, result held until out_ready
module shift_arithmetic_left_seq #(
   parameter int Nbits   = 32,
   parameter int ShWidth = $clog2(Nbits)
) (
   input logic                     clk,
   input logic                     reset,
   shift_arithmetic_left_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state;
   logic [Nbits-1:0]   acc;
   logic [ShWidth-1:0] cnt;
   logic               ovf;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               ovf_next;

   // The bit about to be shifted out must equal the bit that becomes the new MSB.
   assign ovf_next = ovf | (acc[Nbits-1] ^ acc[Nbits-2]);

`ifdef SAL_SATURATE_EN
   localparam logic [Nbits-1:0] MostNeg = {1'b1, {(Nbits-1){1'b0}}};
   localparam logic [Nbits-1:0] MostPos = {1'b0, {(Nbits-1){1'b1}}};
   logic sgn;

   always_ff @(posedge clk) begin
      if (reset)
         sgn <= 1'b0;
      else if (state == IDLE && bus.in_valid)
         sgn <= bus.In[Nbits-1];
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  acc        <= bus.In;
                  cnt        <= bus.ShAmt;
                  ovf        <= 1'b0;
                  in_ready_q <= 1'b0;
                  if (bus.ShAmt == '0) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc <= {acc[Nbits-2:0], 1'b0};
               ovf <= ovf_next;
               cnt <= cnt - 1'b1;
               if (cnt == ShWidth'(1)) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
`ifdef SAL_SATURATE_EN
                  // Clamp on the last shift so Out stays a plain register in DONE.
                  if (ovf_next)
                     acc <= sgn ? MostNeg : MostPos;
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.Out       = acc;
   assign bus.Overflow  = ovf;
endmodule

// File: tb/tb_shift_arithmetic_left_seq.sv
// Randomized self-checking bench for shift_arithmetic_left_seq against a multiply-based model.
module tb_shift_arithmetic_left_seq;
   localparam int N  = 32;
   localparam int SW = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   shift_arithmetic_left_seq_if #(.Nbits(N), .ShWidth(SW)) bus ();

   shift_arithmetic_left_seq #(.Nbits(N), .ShWidth(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result is In * 2^sh evaluated in 64 bits; overflow when truncation changes the value.
   function automatic logic [N:0] model(input logic [N-1:0] a, input int sh);
      longint full;
      logic [N-1:0] trunc;
      logic ov;
      full  = longint'($signed(a)) * (longint'(1) << sh);
      trunc = full[N-1:0];
      ov    = (longint'($signed(trunc)) != full);
`ifdef SAL_SATURATE_EN
      if (ov) trunc = a[N-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return {ov, trunc};
   endfunction

   typedef struct {
      logic [N-1:0] a;
      int           sh;
      int           acc_cyc;
   } op_t;

   op_t q[$];
   bit  seen    = 1'b0;
   bit  hs_prev = 1'b0;

   always @(negedge clk) begin
      logic [N:0] e;
      if (reset) begin
         q.delete();
         seen    = 1'b0;
         hs_prev = 1'b0;
      end else begin
         if (hs_prev) begin
            chk("in_ready_after_hs", N'(bus.in_ready), 1);
            chk("out_valid_after_hs", N'(bus.out_valid), 0);
         end
         hs_prev = 1'b0;
         if (bus.out_valid) begin
            chk("in_ready_in_done", N'(bus.in_ready), 0);
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
               e = model(q[0].a, q[0].sh);
               chk("out", bus.Out, e[N-1:0]);
               chk("overflow", N'(bus.Overflow), N'(e[N]));
               if (!seen) begin
                  chk("latency", N'(cyc), N'(q[0].acc_cyc + q[0].sh + 1));
                  seen = 1'b1;
               end
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  seen    = 1'b0;
                  hs_prev = 1'b1;
               end
            end
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back('{bus.In, int'(bus.ShAmt), cyc});
      end
   end

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got timeout, expected handshake", name);
   endtask

   task automatic send(input logic [N-1:0] a, input int sh);
      int t;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.In       = a;
      bus.ShAmt    = SW'(sh);
      for (t = 0; t < 100; t++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      if (t == 100) timeout("accept");
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.In       = $urandom;
      bus.ShAmt    = SW'($urandom);
   endtask

   task automatic drain(input int pct);
      int t;
      for (t = 0; t < 200; t++) begin
         bus.out_ready = ($urandom_range(0, 99) < pct);
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) break;
         @(posedge clk); #1;
      end
      if (t == 200) timeout("drain");
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [N:0]   m;
      logic [N-1:0] a;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.In        = '0;
      bus.ShAmt     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", N'(bus.out_valid), 0);
      chk("rst_in_ready", N'(bus.in_ready), 1);
      chk("rst_out", bus.Out, 0);
      chk("rst_overflow", N'(bus.Overflow), 0);
      reset = 1'b0;

      m = model(32'h0000_0003, 3);  chk("pin_small", m, 33'h0_0000_0018);
      m = model(32'hFFFF_FFF0, 4);  chk("pin_neg", m, 33'h0_FFFF_FF00);
`ifdef SAL_SATURATE_EN
      m = model(32'h4000_0000, 1);  chk("pin_posovf", m, 33'h1_7FFF_FFFF);
      m = model(32'hC000_0000, 2);  chk("pin_negovf", m, 33'h1_8000_0000);
`else
      m = model(32'h4000_0000, 1);  chk("pin_posovf", m, 33'h1_8000_0000);
      m = model(32'hC000_0000, 2);  chk("pin_negovf", m, 33'h1_0000_0000);
`endif

      send(32'h0000_0003, 3);   drain(100);
      send(32'hFFFF_FFF0, 4);   drain(100);
      send(32'h4000_0000, 1);   drain(50);
      send(32'hC000_0000, 2);   drain(100);

      // Zero shift with backpressure and a competing operand that must be ignored.
      send(32'h8000_0001, 0);
      bus.in_valid  = 1'b1;
      bus.In        = 32'h1234_5678;
      bus.ShAmt     = SW'(5);
      bus.out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("bp_hold_out", bus.Out, 32'h8000_0001);
      bus.in_valid = 1'b0;
      drain(100);

      // Reset in cycle 5 of a long shift.
      send(32'h0000_0001, 20);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("midrst_out_valid", N'(bus.out_valid), 0);
      chk("midrst_in_ready", N'(bus.in_ready), 1);
      chk("midrst_out", bus.Out, 0);
      chk("midrst_overflow", N'(bus.Overflow), 0);
      send(32'h0000_0007, 5);   drain(100);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0:       a = $urandom;
            1:       a = 32'($urandom_range(0, 255));
            2:       a = -32'($urandom_range(1, 255));
            default: a = {2'($urandom), 30'($urandom_range(0, 15))};
         endcase
         send(a, $urandom_range(0, N-1));
         drain($urandom_range(30, 100));
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
